grostl_shift_bytes_buf: RTL and testbench



---
 rtl/grostl_shift_bytes_buf.sv | 100 ++++++++++
 tb/tb_grostl_shift_bytes_buf.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grostl_shift_bytes_buf.sv
// Column-serial ShiftBytes stage for the 64-bit Groestl datapath.
// Eight incoming columns of a 512-bit state are written into one bank of a
// ping-pong byte buffer. The other bank drains one rotated column per beat,
// so filling and draining overlap at one column per cycle.
module grostl_shift_bytes_buf (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [0:7][7:0] in_data,
    input  logic            in_q_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [0:7][7:0] out_data,
    output logic            out_q_sel,
    output logic            out_first,
    output logic            out_last
);

    // Q shift vector; the P shift vector is the identity (sigma[i] = i).
    localparam logic [0:7][2:0] SIGMA_Q = {3'd1, 3'd3, 3'd5, 3'd7,
                                           3'd0, 3'd2, 3'd4, 3'd6};

    logic [0:7][7:0] mem [0:1][0:7];
    logic [1:0]      full;
    logic [1:0]      tag;
    logic            wb;
    logic            rb;
    logic [2:0]      wc;
    logic [2:0]      rc;
    logic            accept;
    logic            drain;

    // A bank being filled is never full, so wb and rb banks never collide
    // on a simultaneous accept and drain.
    assign in_ready  = !full[wb];
    assign out_valid = full[rb];
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    assign out_q_sel = tag[rb];
    assign out_first = (rc == 3'd0);
    assign out_last  = (rc == 3'd7);

    // Column storage: write the accepted column into the fill bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned c = 0; c < 8; c++) begin
                    mem[b][c] <= '0;
                end
            end
        end else if (accept) begin
            mem[wb][wc] <= in_data;
        end
    end

    // Fill/drain pointers, bank full flags and per-bank permutation tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
            tag  <= '0;
            wb   <= 1'b0;
            rb   <= 1'b0;
            wc   <= '0;
            rc   <= '0;
        end else begin
            if (accept) begin
                if (wc == 3'd0) begin
                    tag[wb] <= in_q_sel;
                end
                wc <= wc + 3'd1;
                if (wc == 3'd7) begin
                    full[wb] <= 1'b1;
                    wb       <= ~wb;
                end
            end
            if (drain) begin
                rc <= rc + 3'd1;
                if (rc == 3'd7) begin
                    full[rb] <= 1'b0;
                    rb       <= ~rb;
                end
            end
        end
    end

    // Row i of the output column reads column (rc + sigma[i]) mod 8 of the
    // drain bank; the 3-bit sum wraps naturally.
    always_comb begin
        logic [2:0] sel;
        out_data = '0;
        sel      = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            sel         = rc + (tag[rb] ? SIGMA_Q[i] : 3'(i));
            out_data[i] = mem[rb][sel][i];
        end
    end

endmodule

// File: tb/tb_grostl_shift_bytes_buf.sv
// Directed and randomized check of the ShiftBytes ping-pong buffer against
// a queue-based reference model of whole states.
module tb_grostl_shift_bytes_buf;

    typedef logic [0:7][7:0] col_t;
    typedef struct packed {
        logic             q;
        logic [0:7][63:0] c;
    } st_t;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_ready;
    col_t in_data;
    logic in_q_sel;
    logic out_valid;
    logic out_ready;
    col_t out_data;
    logic out_q_sel;
    logic out_first;
    logic out_last;

    grostl_shift_bytes_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_q_sel  (in_q_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_q_sel (out_q_sel),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    st_t              sq[$];
    st_t              cur;
    int               in_cnt = 0;
    int               oc = 0;
    logic [0:7][63:0] nxt_state;
    bit               nxt_q;
    bit               rnd_data = 0;
    bit               q_plan[$];
    int               acc_cnt, drn_cnt, ncyc, first_drn, last_drn;
    int               states_in, states_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic col_t pat(input int j);
        col_t r;
        for (int i = 0; i < 8; i++) r[i] = {4'(j), 4'(i)};
        return r;
    endfunction

    function automatic col_t exp_col(input st_t s, input int o);
        int   sig_p [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        int   sig_q [8] = '{1, 3, 5, 7, 0, 2, 4, 6};
        col_t r;
        col_t c;
        int   k;
        for (int i = 0; i < 8; i++) begin
            k    = (o + (s.q ? sig_q[i] : sig_p[i])) % 8;
            c    = s.c[k];
            r[i] = c[i];
        end
        return r;
    endfunction

    task automatic refill();
        if (q_plan.size() != 0) nxt_q = q_plan.pop_front();
        else nxt_q = rnd_data ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int j = 0; j < 8; j++)
            nxt_state[j] = rnd_data ? {$urandom, $urandom} : pat(j);
    endtask

    task automatic clr_counts();
        acc_cnt = 0; drn_cnt = 0; ncyc = 0; first_drn = -1; last_drn = -1;
        states_in = 0; states_out = 0;
    endtask

    // One clock: drive inputs, check outputs against the model, advance.
    task automatic cycle(input bit iv, input bit ordy);
        bit acc;
        bit drn;
        in_valid  = iv;
        in_data   = nxt_state[in_cnt];
        in_q_sel  = (in_cnt == 0) ? nxt_q : 1'($urandom_range(0, 1));
        out_ready = ordy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(sq.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(sq.size() != 0));
        if (sq.size() != 0) begin
            chk("out_data", out_data, exp_col(sq[0], oc));
            chk("out_q_sel", 64'(out_q_sel), 64'(sq[0].q));
            chk("out_first", 64'(out_first), 64'(oc == 0));
            chk("out_last", 64'(out_last), 64'(oc == 7));
        end
        acc = iv && (sq.size() < 2);
        drn = ordy && (sq.size() != 0);
        @(posedge clk);
        #1;
        if (drn) begin
            if (first_drn < 0) first_drn = ncyc;
            last_drn = ncyc;
            drn_cnt++;
            oc++;
            if (oc == 8) begin
                void'(sq.pop_front());
                oc = 0;
                states_out++;
            end
        end
        if (acc) begin
            acc_cnt++;
            cur.c[in_cnt] = in_data;
            if (in_cnt == 0) cur.q = in_q_sel;
            in_cnt++;
            if (in_cnt == 8) begin
                sq.push_back(cur);
                in_cnt = 0;
                states_in++;
                refill();
            end
        end
        ncyc++;
    endtask

    task automatic drain_all();
        for (int k = 0; k < 40 && sq.size() != 0; k++) cycle(1'b0, 1'b1);
        chk("drain_timeout", 64'(sq.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_q_sel = 1'b0; out_ready = 1'b0;
        cur = '0;
        refill();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_q_sel", 64'(out_q_sel), 64'd0);
        chk("rst_out_first", 64'(out_first), 64'd1);
        chk("rst_out_last", 64'(out_last), 64'd0);
        rst_n = 1'b1;

        // P state, out_ready high
        clr_counts();
        for (int j = 0; j < 8; j++) cycle(1'b1, 1'b1);
        chk("p_latency", 64'(out_valid), 64'd1);
        chk("p_col0", out_data, 64'h0011223344556677);
        chk("p_first", 64'(out_first), 64'd1);
        for (int j = 0; j < 7; j++) cycle(1'b0, 1'b1);
        chk("p_col7", out_data, 64'h7001122334455667);
        chk("p_last", 64'(out_last), 64'd1);
        cycle(1'b0, 1'b1);
        chk("p_done", 64'(out_valid), 64'd0);

        // Q state
        q_plan.push_back(1'b1);
        refill();
        for (int j = 0; j < 8; j++) cycle(1'b1, 1'b0);
        chk("q_col0", out_data, 64'h1031527304254667);
        chk("q_tag", 64'(out_q_sel), 64'd1);
        drain_all();

        // Back-to-back P then Q, no bubbles
        q_plan.push_back(1'b0);
        q_plan.push_back(1'b1);
        refill();
        clr_counts();
        for (int j = 0; j < 16; j++) cycle(1'b1, 1'b1);
        chk("b2b_accepts", 64'(acc_cnt), 64'd16);
        drain_all();
        chk("b2b_drains", 64'(drn_cnt), 64'd16);
        chk("b2b_no_bubble", 64'(last_drn - first_drn), 64'd15);

        // Full backpressure: both banks fill, then P bank drains first
        q_plan.push_back(1'b0);
        q_plan.push_back(1'b1);
        refill();
        clr_counts();
        for (int j = 0; j < 20; j++) cycle(1'b1, 1'b0);
        chk("bp_accepts", 64'(acc_cnt), 64'd16);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_first_tag", 64'(out_q_sel), 64'd0);
        for (int j = 0; j < 7; j++) cycle(1'b0, 1'b1);
        chk("bp_still_low", 64'(in_ready), 64'd0);
        chk("bp_last", 64'(out_last), 64'd1);
        cycle(1'b0, 1'b1);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        chk("bp_second_tag", 64'(out_q_sel), 64'd1);
        drain_all();

        // Reset with one full bank and 5 columns of the next state
        clr_counts();
        for (int j = 0; j < 13; j++) cycle(1'b1, 1'b0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        sq.delete();
        in_cnt = 0;
        oc = 0;
        refill();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) cycle(1'b1, 1'b0);
        chk("post_rst_first", 64'(out_first), 64'd1);
        chk("post_rst_col0", out_data, 64'h0011223344556677);
        drain_all();

        // Randomized traffic, 200 mixed states
        rnd_data = 1'b1;
        refill();
        clr_counts();
        for (int k = 0; k < 8000 && states_out < 200; k++)
            cycle((states_in < 200) && ($urandom_range(0, 3) != 0), $urandom_range(0, 3) != 0);
        chk("rnd_states", 64'(states_out), 64'd200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
